// File: rtl/aoi21_bist_ctrl_if.sv
// Supervisor/cell-side signal bundle for the AOI21 BIST sequencer.
// err_cnt exists only when AOI21_BIST_ERRCNT_EN is defined.
interface aoi21_bist_ctrl_if;
    logic       start;
    logic       y;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_idx;
`ifdef AOI21_BIST_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    // Supervisor and cell side: requests runs, returns the cell output.
    modport master (
        output start, y,
        input  a, b, c, busy, done, pass, fail_idx
`ifdef AOI21_BIST_ERRCNT_EN
        , input err_cnt
`endif
    );

    // Sequencer side.
    modport slave (
        input  start, y,
        output a, b, c, busy, done, pass, fail_idx
`ifdef AOI21_BIST_ERRCNT_EN
        , output err_cnt
`endif
    );
endinterface

// File: rtl/aoi21_bist_ctrl.sv
// BIST sequencer: sweeps all {a,b,c} vectors through one AOI21 cell and checks y.
// Optional feature macro AOI21_BIST_ERRCNT_EN: run to completion and count mismatches.
module aoi21_bist_ctrl #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned PASSES = 1
) (
    input logic              clk,
    input logic              rst,
    aoi21_bist_ctrl_if.slave bus
);
    localparam int unsigned SCNT_W = 4;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned VEC_W  = 3;
    localparam logic [SCNT_W-1:0] LAST_SCNT = SCNT_W'(SETTLE - 1);
    localparam logic [PC_W-1:0]   LAST_PC   = PC_W'(PASSES - 1);
    localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(7);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t             state;
    logic [VEC_W-1:0]   vi;
    logic [PC_W-1:0]    pc;
    logic [SCNT_W-1:0]  scnt;
    logic               err_seen;

    logic exp_y_c;
    logic mismatch_c;
    logic last_vec_c;
    logic stop_c;

    // Golden response of the vector currently on the cell; X/Z on y is a mismatch.
    assign exp_y_c    = ~((bus.a & bus.b) | bus.c);
    assign mismatch_c = (bus.y !== exp_y_c);
    assign last_vec_c = (vi == LAST_VEC) && (pc == LAST_PC);
`ifdef AOI21_BIST_ERRCNT_EN
    assign stop_c = last_vec_c;
`else
    assign stop_c = last_vec_c || mismatch_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            vi           <= '0;
            pc           <= '0;
            scnt         <= '0;
            err_seen     <= 1'b0;
            bus.a        <= 1'b0;
            bus.b        <= 1'b0;
            bus.c        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.pass     <= 1'b0;
            bus.fail_idx <= '0;
`ifdef AOI21_BIST_ERRCNT_EN
            bus.err_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state        <= APPLY;
                        vi           <= '0;
                        pc           <= '0;
                        scnt         <= '0;
                        err_seen     <= 1'b0;
                        {bus.a, bus.b, bus.c} <= '0;
                        bus.busy     <= 1'b1;
                        bus.pass     <= 1'b0;
                        bus.fail_idx <= '0;
`ifdef AOI21_BIST_ERRCNT_EN
                        bus.err_cnt  <= '0;
`endif
                    end
                end

                APPLY: begin
                    if (scnt == LAST_SCNT) begin
                        state <= CHECK;
                        scnt  <= '0;
                    end else begin
                        scnt <= scnt + SCNT_W'(1);
                    end
                end

                CHECK: begin
                    // Only the first mismatch of a run is reported in fail_idx.
                    if (mismatch_c) begin
                        err_seen <= 1'b1;
                        if (!err_seen) begin
                            bus.fail_idx <= vi;
                        end
`ifdef AOI21_BIST_ERRCNT_EN
                        if (bus.err_cnt != 8'hFF) begin
                            bus.err_cnt <= bus.err_cnt + 8'd1;
                        end
`endif
                    end
                    vi <= vi + VEC_W'(1);
                    if (vi == LAST_VEC) begin
                        pc <= pc + PC_W'(1);
                    end
                    if (stop_c) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        bus.pass <= !(err_seen || mismatch_c);
                        {bus.a, bus.b, bus.c} <= '0;
                    end else begin
                        state <= APPLY;
                        {bus.a, bus.b, bus.c} <= vi + VEC_W'(1);
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aoi21_bist_ctrl.sv
// Scoreboard bench for aoi21_bist_ctrl: two instances (1 and 3 sweeps) driven by
// behavioural AOI21 cells with injectable faults; expected verdicts from a sweep model.
module tb_aoi21_bist_ctrl;
    localparam int unsigned S0 = 2;
    localparam int unsigned P0 = 1;
    localparam int unsigned S1 = 2;
    localparam int unsigned P1 = 3;
    localparam int unsigned BOUND = 400;

    typedef struct {
        int unsigned done_cyc;
        logic        pass;
        logic [2:0]  fidx;
        int unsigned ecnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          dones0 = 0;
    int          dones1 = 0;
    int          mode0 = 0;
    int          mode1 = 0;
    logic [7:0]  mask0 = '0;
    logic [7:0]  mask1 = '0;
    logic [7:0]  ec0;
    logic [7:0]  ec1;
    exp_t        sb0[$];
    exp_t        sb1[$];

    aoi21_bist_ctrl_if bus0 ();
    aoi21_bist_ctrl_if bus1 ();

    aoi21_bist_ctrl #(.SETTLE(S0), .PASSES(P0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    aoi21_bist_ctrl #(.SETTLE(S1), .PASSES(P1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

`ifdef AOI21_BIST_ERRCNT_EN
    assign ec0 = bus0.err_cnt;
    assign ec1 = bus1.err_cnt;
`else
    assign ec0 = '0;
    assign ec1 = '0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cell under test: mode 1 stuck-at-1, mode 2 stuck-at-0, else AOI21 with per-vector flips.
    function automatic logic cell_y(int mode, logic [7:0] mask, logic [2:0] v);
        logic good;
        good = ~((v[2] & v[1]) | v[0]);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return good ^ mask[v];
    endfunction

    always_comb bus0.y = cell_y(mode0, mask0, {bus0.a, bus0.b, bus0.c});
    always_comb bus1.y = cell_y(mode1, mask1, {bus1.a, bus1.b, bus1.c});

    // Reference: walk the sweeps against the truth table, stopping early unless counting.
    function automatic exp_t model(int unsigned settle, int unsigned passes, int mode,
                                   logic [7:0] mask, int unsigned t0);
        exp_t        e;
        logic [7:0]  golden;
        logic [2:0]  vv;
        int unsigned n;
        int unsigned errs;
        logic        stop;
        golden = 8'b0001_0101;
        n = 0;
        errs = 0;
        stop = 1'b0;
        e.fidx = 3'd0;
        for (int unsigned p = 0; p < passes; p++) begin
            for (int unsigned v = 0; v < 8; v++) begin
                if (!stop) begin
                    vv = 3'(v);
                    n++;
                    if (cell_y(mode, mask, vv) != golden[vv]) begin
                        if (errs == 0) e.fidx = vv;
                        errs++;
`ifndef AOI21_BIST_ERRCNT_EN
                        stop = 1'b1;
`endif
                    end
                end
            end
        end
        e.done_cyc = t0 + 1 + n * (settle + 1);
        e.pass     = (errs == 0);
        e.ecnt     = (errs > 255) ? 255 : errs;
        return e;
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_done(string tag, exp_t e, logic busy, logic [2:0] abc,
                              logic pass, logic [2:0] fidx, logic [7:0] ecnt);
        chk({tag, "_done_cycle"}, int'(cyc), int'(e.done_cyc));
        chk({tag, "_done_busy"}, int'(busy), 0);
        chk({tag, "_done_abc"}, int'(abc), 0);
        chk({tag, "_pass"}, int'(pass), int'(e.pass));
        chk({tag, "_fail_idx"}, int'(fidx), int'(e.fidx));
`ifdef AOI21_BIST_ERRCNT_EN
        chk({tag, "_err_cnt"}, int'(ecnt), int'(e.ecnt));
`else
        if (ecnt != 8'd0) chk({tag, "_err_cnt_tied"}, int'(ecnt), 0);
`endif
    endtask

    task automatic chk_zero(string tag, logic [2:0] abc, logic busy, logic done,
                            logic pass, logic [2:0] fidx, logic [7:0] ecnt);
        chk({tag, "_abc"}, int'(abc), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_fail_idx"}, int'(fidx), 0);
`ifdef AOI21_BIST_ERRCNT_EN
        chk({tag, "_err_cnt"}, int'(ecnt), 0);
`else
        if (ecnt != 8'd0) chk({tag, "_err_cnt_tied"}, int'(ecnt), 0);
`endif
    endtask

    // Monitor: every done pulse is matched against the oldest expected verdict.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus0.done) begin
            dones0++;
            if (sb0.size() == 0) chk("dut0_unexpected_done", 1, 0);
            else begin
                e = sb0.pop_front();
                check_done("dut0", e, bus0.busy, {bus0.a, bus0.b, bus0.c},
                           bus0.pass, bus0.fail_idx, ec0);
            end
        end
        if (!rst && bus1.done) begin
            dones1++;
            if (sb1.size() == 0) chk("dut1_unexpected_done", 1, 0);
            else begin
                e = sb1.pop_front();
                check_done("dut1", e, bus1.busy, {bus1.a, bus1.b, bus1.c},
                           bus1.pass, bus1.fail_idx, ec1);
            end
        end
    end

    task automatic start_run(int inst, int mode, logic [7:0] mask, output int unsigned t0);
        if (inst == 0) begin mode0 = mode; mask0 = mask; end
        else begin mode1 = mode; mask1 = mask; end
        @(posedge clk); #1;
        t0 = cyc;
        if (inst == 0) begin
            bus0.start = 1'b1;
            sb0.push_back(model(S0, P0, mode, mask, t0));
        end else begin
            bus1.start = 1'b1;
            sb1.push_back(model(S1, P1, mode, mask, t0));
        end
        @(posedge clk); #1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_done(int inst);
        int n;
        n = 0;
        while (((inst == 0) ? sb0.size() : sb1.size()) != 0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (((inst == 0) ? sb0.size() : sb1.size()) != 0) begin
            chk((inst == 0) ? "dut0_done_timeout" : "dut1_done_timeout", 1, 0);
            if (inst == 0) sb0.delete(); else sb1.delete();
        end
    endtask

    initial begin
        int unsigned t0;
        int          d;
        int          n;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset0", {bus0.a, bus0.b, bus0.c}, bus0.busy, bus0.done, bus0.pass, bus0.fail_idx, ec0);
        chk_zero("reset1", {bus1.a, bus1.b, bus1.c}, bus1.busy, bus1.done, bus1.pass, bus1.fail_idx, ec1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Good cell: every vector held SETTLE+1 cycles with busy high.
        start_run(0, 0, 8'h00, t0);
        for (int unsigned k = 0; k < 8 * (S0 + 1); k++) begin
            @(negedge clk);
            chk("good_vector", int'({bus0.a, bus0.b, bus0.c}), int'(k / (S0 + 1)));
            chk("good_busy", int'(bus0.busy), 1);
        end
        wait_done(0);

        // Stuck-at faults and single-vector faults.
        start_run(0, 1, 8'h00, t0); wait_done(0);
        start_run(1, 1, 8'h00, t0); wait_done(1);
        start_run(0, 2, 8'h00, t0); wait_done(0);
        start_run(0, 0, 8'h40, t0); wait_done(0);
        start_run(0, 0, 8'h80, t0); wait_done(0);

        for (int i = 0; i < 8; i++) begin
            start_run(0, 0, 8'($urandom), t0);
            wait_done(0);
        end
        for (int i = 0; i < 3; i++) begin
            start_run(1, 0, 8'($urandom), t0);
            wait_done(1);
        end

        // Starts while busy and during the done cycle are dropped.
        start_run(0, 0, 8'h00, t0);
        repeat (5) @(negedge clk);
        chk("ignore_busy_high", int'(bus0.busy), 1);
        d = dones0;
        bus0.start = 1'b1;
        repeat (3) @(negedge clk);
        bus0.start = 1'b0;
        n = 0;
        while (!bus0.done && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("ignore_done_seen", int'(bus0.done), 1);
        bus0.start = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        repeat (40) @(negedge clk);
        chk("ignore_done_count", dones0 - d, 1);
        chk("ignore_verdict", int'(bus0.pass), 1);
        chk("ignore_idle_busy", int'(bus0.busy), 0);

        // Three sweeps, then an immediate re-run clears the previous verdict.
        start_run(1, 0, 8'h00, t0); wait_done(1);
        start_run(1, 0, 8'h00, t0);
        @(negedge clk);
        chk("rerun_pass_cleared", int'(bus1.pass), 0);
        chk("rerun_busy", int'(bus1.busy), 1);
        wait_done(1);
        start_run(1, 0, 8'h21, t0); wait_done(1);

        // Reset mid-run on vector 5 aborts without a verdict.
        start_run(0, 0, 8'h00, t0);
        n = 0;
        while ({bus0.a, bus0.b, bus0.c} != 3'd5 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("midrun_reached_vi5", int'({bus0.a, bus0.b, bus0.c}), 5);
        @(posedge clk); #1;
        rst = 1'b1;
        sb0.delete();
        sb1.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midrun_reset", {bus0.a, bus0.b, bus0.c}, bus0.busy, bus0.done, bus0.pass, bus0.fail_idx, ec0);
        repeat (3) @(negedge clk);
        chk("post_reset_idle", int'(bus0.busy), 0);
        start_run(0, 0, 8'h02, t0); wait_done(0);

        repeat (4) @(negedge clk);
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
